// File: rtl/memsplit_pkg.sv
// Shared types and constants for the MemSplit32 initiator slice.
package memsplit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADDEAD;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

endpackage

// File: rtl/memsplit32_if.sv
// MemSplit32 split-transaction bus: request phase (req/ack) and a separate read-response phase.
interface MemSplit32;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport Master (output req, we, addr, wdata, be, input ack, resp, rdata);
  modport Slave  (input req, we, addr, wdata, be, output ack, resp, rdata);
endinterface

// File: rtl/memsplit_rd_tracker.sv
// Outstanding-read bookkeeping: credit, in-order response acceptance and stray detection.
// Optional read watchdog with late-response dropping under MEMSPLIT_INITIATOR_TIMEOUT_EN.
module memsplit_rd_tracker #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rd_ack,
  input  logic i_resp,
  output logic o_credit_avail,
  output logic o_rsp_accept,
  output logic o_timeout_fire,
  output logic o_pending,
  output logic o_stray
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] r_out;
  logic             r_stray;
  logic             w_out_nz;
  logic             w_drop;
  logic             w_dec;
  logic             w_stray_hit;

  assign w_out_nz = (r_out != '0);

`ifdef MEMSPLIT_INITIATOR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0]  r_wdog;
  logic [CNT_W-1:0] r_drop;

  // A response always beats a timeout landing in the same cycle.
  assign w_drop         = i_resp && (r_drop != '0);
  assign o_timeout_fire = w_out_nz && !i_resp && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wdog <= '0;
      r_drop <= '0;
    end else begin
      if (w_drop)
        r_drop <= r_drop - CNT_W'(1);
      else if (o_timeout_fire && (r_drop != '1))
        r_drop <= r_drop + CNT_W'(1);

      if (i_resp || o_timeout_fire || (i_rd_ack && !w_out_nz))
        r_wdog <= '0;
      else if (w_out_nz)
        r_wdog <= r_wdog + WD_W'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_drop           = 1'b0;
  assign o_timeout_fire   = 1'b0;
`endif

  assign o_rsp_accept   = i_resp && !w_drop && w_out_nz;
  assign w_stray_hit    = i_resp && !w_drop && !w_out_nz;
  assign w_dec          = o_rsp_accept || o_timeout_fire;
  assign o_credit_avail = (r_out < CNT_W'(MAX_OUTSTANDING));
  assign o_pending      = w_out_nz;
  assign o_stray        = r_stray;

  // Accept gating keeps the counter at or below MAX_OUTSTANDING, so no wrap guard.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out   <= '0;
      r_stray <= 1'b0;
    end else begin
      case ({i_rd_ack, w_dec})
        2'b10:   r_out <= r_out + CNT_W'(1);
        2'b01:   r_out <= r_out - CNT_W'(1);
        default: r_out <= r_out;
      endcase
      if (w_stray_hit)
        r_stray <= 1'b1;
    end
  end

endmodule

// File: rtl/memsplit_initiator.sv
// MemSplit32 master: valid/ready command stream in, bus requests out, in-order read responses back.
// Build option MEMSPLIT_INITIATOR_TIMEOUT_EN adds a read watchdog returning ERR_RDATA with rsp_err_o.
module memsplit_initiator
  import memsplit_pkg::*;
#(
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          TIMEOUT_CYCLES  = 256,
  parameter logic [31:0] ERR_RDATA       = ERR_RDATA_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  MemSplit32.Master        bus,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [31:0]      cmd_addr_bi,
  input  logic [31:0]      cmd_wdata_bi,
  input  logic [3:0]       cmd_be_bi,
  output logic             rsp_valid_o,
  output logic [31:0]      rsp_rdata_bo,
  output logic             rsp_err_o,
  output logic             wr_done_o,
  output logic             busy_o,
  output logic             stray_resp_o
);

  state_t      r_state;
  state_t      w_state_nxt;
  cmd_t        r_cmd;
  cmd_t        w_cmd_in;
  logic        r_wr_done;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic w_accept;
  logic w_ready;
  logic w_ack;
  logic w_rd_ack;
  logic w_credit;
  logic w_rsp_accept;
  logic w_timeout_fire;
  logic w_pending;
  logic w_stray;

  assign w_cmd_in = '{we: cmd_we_i, addr: cmd_addr_bi, wdata: cmd_wdata_bi, be: cmd_be_bi};

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ready     = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = w_credit;
        if (cmd_valid_i && w_credit) begin
          w_accept    = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.ack) begin
          w_ack       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_rd_ack = w_ack && !r_cmd.we;

  // Request fields come straight from the command register so they stay frozen until ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_wr_done   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)
        r_cmd <= w_cmd_in;
      r_wr_done   <= w_ack && r_cmd.we;
      r_rsp_valid <= w_rsp_accept || w_timeout_fire;
      r_rsp_err   <= w_timeout_fire;
      if (w_rsp_accept)
        r_rsp_rdata <= bus.rdata;
      else if (w_timeout_fire)
        r_rsp_rdata <= ERR_RDATA;
    end
  end

  memsplit_rd_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) u_rd_tracker (
    .i_clk          (clk_i),
    .i_rst          (rst_i),
    .i_rd_ack       (w_rd_ack),
    .i_resp         (bus.resp),
    .o_credit_avail (w_credit),
    .o_rsp_accept   (w_rsp_accept),
    .o_timeout_fire (w_timeout_fire),
    .o_pending      (w_pending),
    .o_stray        (w_stray)
  );

  assign bus.req   = (r_state == REQ);
  assign bus.we    = r_cmd.we;
  assign bus.addr  = r_cmd.addr;
  assign bus.wdata = r_cmd.wdata;
  assign bus.be    = r_cmd.be;

  assign cmd_ready_o  = w_ready;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_rdata_bo = r_rsp_rdata;
  assign rsp_err_o    = r_rsp_err;
  assign wr_done_o    = r_wr_done;
  assign busy_o       = (r_state != IDLE) || w_pending;
  assign stray_resp_o = w_stray;

endmodule

// File: doc/memsplit_initiator.md
Name: memsplit_initiator

Overview:
- Bus initiator (master end) for the MemSplit32 protocol. It converts a simple valid/ready command stream into MemSplit32 requests and returns read data on a response port.
- Used by the tile debug/boot path to program SFR-class slaves (IDCODE, CTRL, IRQ_EN, timer, trace registers) without a CPU.
- Tracks outstanding reads in order and flags protocol anomalies.

Parameters:
- MAX_OUTSTANDING, 4, maximum reads issued but not yet answered (1..15).
- TIMEOUT_CYCLES, 256, cycles to wait for a read resp before an error response is generated (only with the optional feature).
- ERR_RDATA, 32'hDEADDEAD, rdata value returned on an error response.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, synchronous, active-high.
- bus  MemSplit32.Master  -  drives req/we/addr/wdata/be; samples ack/resp/rdata.
- cmd_valid_i  input  1  command valid.
- cmd_ready_o  output  1  command accepted this cycle when valid and ready.
- cmd_we_i  input  1  1 = write, 0 = read.
- cmd_addr_bi  input  32  byte address.
- cmd_wdata_bi  input  32  write data.
- cmd_be_bi  input  4  byte enables.
- rsp_valid_o  output  1  one-cycle pulse; read data or error available.
- rsp_rdata_bo  output  32  read data.
- rsp_err_o  output  1  qualifies rsp_valid_o; 1 = timed-out read.
- wr_done_o  output  1  one-cycle pulse when a write is acked.
- busy_o  output  1  state != IDLE or outstanding != 0.
- stray_resp_o  output  1  sticky; set when resp arrives with zero outstanding reads.

Behaviour:
- Reset (rst_i=1 at clk edge):
  - state=IDLE, bus.req=0, bus.we=0, addr/wdata/be=0.
  - outstanding=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_bo=0, wr_done_o=0, stray_resp_o=0.
  - Reset mid-transaction drops req on the next edge; pending reads are forgotten with no responses.
- States:
  - IDLE: cmd_ready_o = (outstanding < MAX_OUTSTANDING). On accept, register we/addr/wdata/be, set bus.req=1, go to REQ.
  - REQ: cmd_ready_o=0. bus.req and all request fields are held stable until bus.ack=1. On an ack edge, req is deasserted and state returns to IDLE.
    - Read ack: outstanding +1.
    - Write ack: wr_done_o pulses in the following cycle.
- Throughput and latency:
  - Accept → bus.req visible: 1 cycle.
  - Minimum 2 cycles per transaction (ack can be same-cycle as req).
- Response path:
  - bus.resp=1 with outstanding>0: rsp_valid_o=1 and rsp_rdata_bo=bus.rdata on the next cycle, rsp_err_o=0, outstanding −1.
  - Responses are strictly in issue order. There is no backpressure on the response port.
  - bus.resp=1 with outstanding=0: ignored, stray_resp_o set until reset.
- Simultaneous read ack and resp in the same cycle: outstanding unchanged.
- Outstanding counter width is $clog2(MAX_OUTSTANDING+1). It never exceeds MAX_OUTSTANDING because of the ready gating; no wrap.
- Writes produce no rsp_valid_o.

Optional Feature:
- Macro: MEMSPLIT_INITIATOR_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles while outstanding>0 with no resp. It reloads on every resp and on every read ack when the counter was 0.
  - On reaching TIMEOUT_CYCLES−1: pulse rsp_valid_o=1, rsp_err_o=1, rsp_rdata_bo=ERR_RDATA; outstanding −1; drop_cnt +1.
  - While drop_cnt>0, each arriving resp decrements drop_cnt and is discarded with no rsp_valid_o.
  - If timeout and resp fire in the same cycle, the resp wins and the watchdog reloads.
- Undefined: no watchdog or drop_cnt logic; rsp_err_o is tied 0; reads wait forever.

Decomposition:
- Shared package memsplit_pkg:
  - state enum {IDLE, REQ};
  - ERR_RDATA default;
  - command struct (we, addr, wdata, be).
- One sub-module, memsplit_rd_tracker: outstanding counter, stray flag, and the optional watchdog/drop_cnt. Its outputs are credit_avail, rsp_accept and timeout_fire.

Test Plan:
- Write cmd addr=0x10, wdata=0x0000_00FF, be=4'hF to a 1-cycle-ack slave model → bus.req high exactly 1 cycle after accept with fields stable; wr_done_o pulse; no rsp_valid_o.
- Read addr=0x00, slave holds ack low 3 cycles then returns 32'hdeadbeef via resp 1 cycle after ack → req held 4 cycles, rsp_valid_o once with 32'hdeadbeef, busy_o falls after.
- 5 back-to-back reads with MAX_OUTSTANDING=4 and resp withheld → cmd_ready_o low after the 4th ack. After one resp, the 5th is accepted. Data returns in order 0x1, 0x2, 0x3, 0x4, 0x5.
- Inject bus.resp with no outstanding reads → stray_resp_o=1 and stays set; rsp_valid_o stays 0.
- rst_i asserted while in REQ with 2 reads outstanding → next cycle bus.req=0, busy_o=0, outstanding=0. A later resp sets stray_resp_o.
- (MEMSPLIT_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES=16) read never answered → after 16 cycles rsp_err_o=1, rdata=32'hDEADDEAD. A late resp at cycle 20 is dropped with no rsp_valid_o and stray_resp_o stays 0.
